// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master controller: response codes,
// controller state encoding and response-status layout.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Status is {timeout, resp[1:0]}; a timeout reports no AXI response code.
  localparam int          STATUS_TIMEOUT_BIT = 2;
  localparam logic [2:0]  STATUS_TIMEOUT     = 3'(1 << STATUS_TIMEOUT_BIT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_AD = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_A  = 3'd3,
    ST_RD_D  = 3'd4
  } state_t;

endpackage

// File: rtl/axi_timeout_counter.sv
// Transaction watchdog: counts busy cycles since the last clear and flags the
// cycle in which the transaction has used up its TIMEOUT_CYCLES budget.
module axi_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // The registered count lags the current cycle by one, so the budget is
  // exhausted when the count including this cycle reaches TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + 1'b1;
    end
  end

  assign o_expired = i_enable && (count == LAST);

endmodule

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns a command/response handshake into
// AW/W/B or AR/R transactions, with a watchdog that abandons stuck transfers.
module axi_lite_master_ctrl
  import axi_lite_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 4,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_we,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                          o_rsp_valid,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [2:0]                    o_rsp_status,
  output logic                          o_axi_awvalid,
  input  logic                          i_axi_awready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_awaddr,
  output logic                          o_axi_wvalid,
  input  logic                          i_axi_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]   o_axi_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] o_axi_wstrb,
  input  logic                          i_axi_bvalid,
  output logic                          o_axi_bready,
  input  logic [1:0]                    i_axi_bresp,
  output logic                          o_axi_arvalid,
  input  logic                          i_axi_arready,
  output logic [C_AXI_ADDR_WIDTH-1:0]   o_axi_araddr,
  input  logic                          i_axi_rvalid,
  output logic                          o_axi_rready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   i_axi_rdata,
  input  logic [1:0]                    i_axi_rresp
);

  state_t state;
  logic   accept;
  logic   expired;
  logic   aw_done;
  logic   w_done;
  logic   b_hs;
  logic   r_hs;
  logic   abort;

  assign o_cmd_ready = (state == ST_IDLE);
  assign accept      = i_cmd_valid && o_cmd_ready;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = !o_axi_awvalid || i_axi_awready;
  assign w_done  = !o_axi_wvalid  || i_axi_wready;
  assign b_hs    = o_axi_bready && i_axi_bvalid;
  assign r_hs    = o_axi_rready && i_axi_rvalid;

  // A completing B/R handshake in the expiry cycle wins over the timeout.
  assign abort = expired && !b_hs && !r_hs;

  axi_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (accept),
    .i_enable  (state != ST_IDLE),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_rsp_valid   <= 1'b0;
      o_rsp_rdata   <= '0;
      o_rsp_status  <= '0;
      o_axi_awvalid <= 1'b0;
      o_axi_awaddr  <= '0;
      o_axi_wvalid  <= 1'b0;
      o_axi_wdata   <= '0;
      o_axi_wstrb   <= '0;
      o_axi_bready  <= 1'b0;
      o_axi_arvalid <= 1'b0;
      o_axi_araddr  <= '0;
      o_axi_rready  <= 1'b0;
    end else begin
      o_rsp_valid <= 1'b0;
      if (abort) begin
        // Fault recovery: dropping valids mid-handshake is deliberate here.
        o_axi_awvalid <= 1'b0;
        o_axi_wvalid  <= 1'b0;
        o_axi_bready  <= 1'b0;
        o_axi_arvalid <= 1'b0;
        o_axi_rready  <= 1'b0;
        o_rsp_valid   <= 1'b1;
        o_rsp_rdata   <= '0;
        o_rsp_status  <= STATUS_TIMEOUT;
        state         <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (i_cmd_valid) begin
              o_axi_awaddr <= i_cmd_addr;
              o_axi_araddr <= i_cmd_addr;
              o_axi_wdata  <= i_cmd_wdata;
              o_axi_wstrb  <= i_cmd_wstrb;
              if (i_cmd_we) begin
                o_axi_awvalid <= 1'b1;
                o_axi_wvalid  <= 1'b1;
                state         <= ST_WR_AD;
              end else begin
                o_axi_arvalid <= 1'b1;
                state         <= ST_RD_A;
              end
            end
          end

          ST_WR_AD: begin
            if (i_axi_awready) o_axi_awvalid <= 1'b0;
            if (i_axi_wready)  o_axi_wvalid  <= 1'b0;
            if (aw_done && w_done) begin
              o_axi_bready <= 1'b1;
              state        <= ST_WR_B;
            end
          end

          ST_WR_B: begin
            if (b_hs) begin
              o_axi_bready <= 1'b0;
              o_rsp_valid  <= 1'b1;
              o_rsp_rdata  <= '0;
              o_rsp_status <= {1'b0, i_axi_bresp};
              state        <= ST_IDLE;
            end
          end

          ST_RD_A: begin
            if (i_axi_arready) begin
              o_axi_arvalid <= 1'b0;
              o_axi_rready  <= 1'b1;
              state         <= ST_RD_D;
            end
          end

          ST_RD_D: begin
            if (r_hs) begin
              o_axi_rready <= 1'b0;
              o_rsp_valid  <= 1'b1;
              o_rsp_rdata  <= i_axi_rdata;
              o_rsp_status <= {1'b0, i_axi_rresp};
              state        <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Self-checking bench: a cycle-driven AXI4-Lite slave with per-transaction
// latencies, checked against an arithmetic model of response timing and content.
module tb_axi_lite_master_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int T  = 16;
  localparam int MAX_CYCLES = 40;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_we;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [DW/8-1:0] i_cmd_wstrb;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_rdata;
  logic [2:0]    o_rsp_status;
  logic          o_axi_awvalid;
  logic          i_axi_awready;
  logic [AW-1:0] o_axi_awaddr;
  logic          o_axi_wvalid;
  logic          i_axi_wready;
  logic [DW-1:0] o_axi_wdata;
  logic [DW/8-1:0] o_axi_wstrb;
  logic          i_axi_bvalid;
  logic          o_axi_bready;
  logic [1:0]    i_axi_bresp;
  logic          o_axi_arvalid;
  logic          i_axi_arready;
  logic [AW-1:0] o_axi_araddr;
  logic          i_axi_rvalid;
  logic          o_axi_rready;
  logic [DW-1:0] i_axi_rdata;
  logic [1:0]    i_axi_rresp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_lite_master_ctrl #(
    .C_AXI_DATA_WIDTH(DW),
    .C_AXI_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES  (T)
  ) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_we      (i_cmd_we),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wdata   (i_cmd_wdata),
    .i_cmd_wstrb   (i_cmd_wstrb),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_status  (o_rsp_status),
    .o_axi_awvalid (o_axi_awvalid),
    .i_axi_awready (i_axi_awready),
    .o_axi_awaddr  (o_axi_awaddr),
    .o_axi_wvalid  (o_axi_wvalid),
    .i_axi_wready  (i_axi_wready),
    .o_axi_wdata   (o_axi_wdata),
    .o_axi_wstrb   (o_axi_wstrb),
    .i_axi_bvalid  (i_axi_bvalid),
    .o_axi_bready  (o_axi_bready),
    .i_axi_bresp   (i_axi_bresp),
    .o_axi_arvalid (o_axi_arvalid),
    .i_axi_arready (i_axi_arready),
    .o_axi_araddr  (o_axi_araddr),
    .i_axi_rvalid  (i_axi_rvalid),
    .o_axi_rready  (o_axi_rready),
    .i_axi_rdata   (i_axi_rdata),
    .i_axi_rresp   (i_axi_rresp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic drive_slave_idle();
    i_axi_awready = 1'b0;
    i_axi_wready  = 1'b0;
    i_axi_bvalid  = 1'b0;
    i_axi_bresp   = 2'b00;
    i_axi_arready = 1'b0;
    i_axi_rvalid  = 1'b0;
    i_axi_rdata   = '0;
    i_axi_rresp   = 2'b00;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(o_cmd_ready), 64'(1));
    check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'(0));
    check({tag, "_rsp_rdata"}, 64'(o_rsp_rdata), 64'(0));
    check({tag, "_rsp_status"}, 64'(o_rsp_status), 64'(0));
    check({tag, "_valids"}, 64'({o_axi_awvalid, o_axi_wvalid, o_axi_bready,
                                 o_axi_arvalid, o_axi_rready}), 64'(0));
    check({tag, "_addr_data"}, 64'({o_axi_awaddr, o_axi_araddr, o_axi_wdata, o_axi_wstrb}), 64'(0));
  endtask

  // One transaction. For reads, a_lat is the arready delay and d_lat the rvalid
  // delay; for writes a_lat/w_lat delay awready/wready and d_lat delays bvalid.
  // Delays count cycles from the first cycle the controller drives the channel.
  task automatic run_txn(input string tag, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW/8-1:0] ws,
                         input int a_lat, input int w_lat, input int d_lat,
                         input logic [1:0] resp, input logic [DW-1:0] rd);
    int h, c, exp_rsp, exp_a_cnt, exp_w_cnt, exp_rdy_cnt, exp_a_hs, exp_w_hs;
    logic [2:0] exp_status;
    logic [DW-1:0] exp_rdata;
    int got_rsp, a_cnt, w_cnt, rdy_cnt, a_hs, w_hs;
    logic [2:0] got_status;
    logic [DW-1:0] got_rdata, got_wdata;
    logic [AW-1:0] got_addr;
    logic [DW/8-1:0] got_wstrb;
    logic got_ready, a_valid, a_ready, w_ready, rdy, d_valid, d_done;

    // Reference model: cycle 0 is the accept cycle, cycle 1 the first AXI cycle.
    exp_a_hs = 1 + a_lat;
    exp_w_hs = we ? 1 + w_lat : -1;
    h = we ? imax(exp_a_hs, exp_w_hs) : exp_a_hs;
    c = h + 1 + d_lat;
    if (c <= T - 1) begin
      exp_rsp    = c + 1;
      exp_status = {1'b0, resp};
      exp_rdata  = we ? '0 : rd;
    end else begin
      exp_rsp    = T;
      exp_status = 3'b100;
      exp_rdata  = '0;
    end
    exp_a_cnt   = imin(exp_a_hs, T - 1);
    exp_w_cnt   = we ? imin(exp_w_hs, T - 1) : 0;
    exp_rdy_cnt = imax(0, imin(c, T - 1) - h);
    if (exp_a_hs > T - 1) exp_a_hs = -1;
    if (exp_w_hs > T - 1) exp_w_hs = -1;

    got_rsp = -1; a_cnt = 0; w_cnt = 0; rdy_cnt = 0; a_hs = -1; w_hs = -1;
    got_status = '0; got_rdata = '0; got_ready = 1'b0;
    got_addr = '0; got_wdata = '0; got_wstrb = '0; d_done = 1'b0;

    @(negedge clk);
    check({tag, "_idle_rsp"}, 64'(o_rsp_valid), 64'(0));
    check({tag, "_idle_ready"}, 64'(o_cmd_ready), 64'(1));
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_addr  = addr;
    i_cmd_wdata = wd;
    i_cmd_wstrb = ws;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_addr  = AW'($urandom);
    i_cmd_wdata = $urandom;
    i_cmd_wstrb = (DW/8)'($urandom);

    for (int k = 1; k <= MAX_CYCLES; k++) begin
      if (o_rsp_valid) begin
        got_rsp    = k;
        got_status = o_rsp_status;
        got_rdata  = o_rsp_rdata;
        got_ready  = o_cmd_ready;
        break;
      end
      a_valid = we ? o_axi_awvalid : o_axi_arvalid;
      rdy     = we ? o_axi_bready : o_axi_rready;
      a_cnt   += int'(a_valid);
      w_cnt   += int'(o_axi_wvalid);
      rdy_cnt += int'(rdy);
      a_ready = (k >= 1 + a_lat);
      w_ready = we && (k >= 1 + w_lat);
      i_axi_awready = we && a_ready;
      i_axi_arready = !we && a_ready;
      i_axi_wready  = w_ready;
      if (a_valid && a_ready && a_hs < 0) begin
        a_hs     = k;
        got_addr = we ? o_axi_awaddr : o_axi_araddr;
      end
      if (o_axi_wvalid && w_ready && w_hs < 0) begin
        w_hs      = k;
        got_wdata = o_axi_wdata;
        got_wstrb = o_axi_wstrb;
      end
      d_valid = !d_done && a_hs >= 0 && (!we || w_hs >= 0) &&
                (k >= imax(a_hs, we ? w_hs : a_hs) + 1 + d_lat);
      i_axi_bvalid = we && d_valid;
      i_axi_rvalid = !we && d_valid;
      i_axi_bresp  = d_valid ? resp : 2'($urandom);
      i_axi_rresp  = d_valid ? resp : 2'($urandom);
      i_axi_rdata  = d_valid ? rd : $urandom;
      if (d_valid && rdy) d_done = 1'b1;
      @(negedge clk);
    end
    drive_slave_idle();

    check({tag, "_rsp_cycle"}, 64'(got_rsp), 64'(exp_rsp));
    check({tag, "_status"}, 64'(got_status), 64'(exp_status));
    check({tag, "_rdata"}, 64'(got_rdata), 64'(exp_rdata));
    check({tag, "_ready_at_rsp"}, 64'(got_ready), 64'(1));
    check({tag, "_addr_valid_cycles"}, 64'(a_cnt), 64'(exp_a_cnt));
    check({tag, "_wvalid_cycles"}, 64'(w_cnt), 64'(exp_w_cnt));
    check({tag, "_rsp_ready_cycles"}, 64'(rdy_cnt), 64'(exp_rdy_cnt));
    check({tag, "_addr_hs_cycle"}, 64'(a_hs), 64'(exp_a_hs));
    if (a_hs >= 0) check({tag, "_addr"}, 64'(got_addr), 64'(addr));
    if (we) begin
      check({tag, "_w_hs_cycle"}, 64'(w_hs), 64'(exp_w_hs));
      if (w_hs >= 0) begin
        check({tag, "_wdata"}, 64'(got_wdata), 64'(wd));
        check({tag, "_wstrb"}, 64'(got_wstrb), 64'(ws));
      end
    end
  endtask

  function automatic int rand_lat();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(8, 20)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    i_reset     = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_wdata = '0;
    i_cmd_wstrb = '0;
    drive_slave_idle();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    i_reset = 1'b0;

    run_txn("wr_basic", 1'b1, 4'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, '0);
    run_txn("rd_arwait", 1'b0, 4'h4, '0, '0, 2, 0, 0, 2'b00, 32'h12345678);
    run_txn("wr_split", 1'b1, 4'hC, 32'hA5A5_0F0F, 4'h3, 0, 3, 0, 2'b10, '0);
    run_txn("rd_timeout", 1'b0, 4'h0, '0, '0, 100, 0, 0, 2'b00, 32'hFFFF_FFFF);
    run_txn("wr_zero_strb", 1'b1, 4'h2, 32'h0BAD_F00D, 4'h0, 1, 0, 2, 2'b01, '0);
    run_txn("rd_edge_win", 1'b0, 4'h6, '0, '0, 0, 0, 13, 2'b11, 32'hCAFE_0001);
    run_txn("rd_edge_lose", 1'b0, 4'h6, '0, '0, 0, 0, 14, 2'b00, 32'hCAFE_0002);
    run_txn("wr_b_timeout", 1'b1, 4'hA, 32'h1111_2222, 4'h5, 0, 0, 30, 2'b00, '0);

    // Reset while waiting in the read-data phase.
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_we    = 1'b0;
    i_cmd_addr  = 4'hC;
    @(negedge clk);
    i_cmd_valid   = 1'b0;
    i_axi_arready = 1'b1;
    @(negedge clk);
    i_axi_arready = 1'b0;
    check("rst_mid_rready", 64'(o_axi_rready), 64'(1));
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_reset_outputs("rst_mid");
    i_axi_rvalid = 1'b1;
    i_axi_rdata  = 32'h5555_AAAA;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", 64'(o_rsp_valid), 64'(0));
    end
    drive_slave_idle();
    run_txn("wr_after_rst", 1'b1, 4'h4, 32'h0F0F_F0F0, 4'hC, 0, 0, 0, 2'b00, '0);

    for (int n = 0; n < 40; n++) begin
      logic we;
      we = 1'($urandom_range(0, 1));
      run_txn(we ? "rnd_wr" : "rnd_rd", we, AW'($urandom), $urandom, (DW/8)'($urandom),
              rand_lat(), rand_lat(), rand_lat(), 2'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_ctrl.md
Name:
axi_lite_master_ctrl

Overview:
Single-outstanding AXI4-Lite master controller. It converts a simple command/response interface into AXI4-Lite transactions that sequence the team's axi_slave register block, serialises reads and writes, and bounds every transaction with a timeout.

Parameters:
C_AXI_DATA_WIDTH, 32, data width of the command interface and the AXI data path
C_AXI_ADDR_WIDTH, 4, byte address width
TIMEOUT_CYCLES, 16, cycles an issued transaction may wait before it is abandoned (minimum 4)

Ports:
i_clk  in  1  system clock; all logic is on the rising edge
i_reset  in  1  synchronous, active-high reset
i_cmd_valid  in  1  command request
o_cmd_ready  out  1  controller idle; command accepted when valid&ready
i_cmd_we  in  1  1 = write, 0 = read
i_cmd_addr  in  C_AXI_ADDR_WIDTH  byte address
i_cmd_wdata  in  C_AXI_DATA_WIDTH  write data
i_cmd_wstrb  in  C_AXI_DATA_WIDTH/8  write byte strobes
o_rsp_valid  out  1  one-cycle completion pulse; no backpressure
o_rsp_rdata  out  C_AXI_DATA_WIDTH  read data; 0 for writes and timeouts
o_rsp_status  out  3  {timeout, resp[1:0]}
o_axi_awvalid  out  1  write address valid
i_axi_awready  in  1  write address ready
o_axi_awaddr  out  C_AXI_ADDR_WIDTH  write address
o_axi_wvalid  out  1  write data valid
i_axi_wready  in  1  write data ready
o_axi_wdata  out  C_AXI_DATA_WIDTH  write data
o_axi_wstrb  out  C_AXI_DATA_WIDTH/8  write strobes
i_axi_bvalid  in  1  write response valid
o_axi_bready  out  1  write response ready
i_axi_bresp  in  2  write response code
o_axi_arvalid  out  1  read address valid
i_axi_arready  in  1  read address ready
o_axi_araddr  out  C_AXI_ADDR_WIDTH  read address
i_axi_rvalid  in  1  read data valid
o_axi_rready  out  1  read data ready
i_axi_rdata  in  C_AXI_DATA_WIDTH  read data
i_axi_rresp  in  2  read response code

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0 except o_cmd_ready=1; o_rsp_valid=0, o_rsp_rdata=0, o_rsp_status=0; address/data registers 0. The slave's prot/cache inputs are tied to 0 at integration.
- o_cmd_ready = (state==IDLE). All other outputs are registered. On acceptance the controller latches we, addr, wdata and wstrb unchanged (an all-zero wstrb is passed through).
- IDLE → WR_AD (write) or RD_A (read). The cycle after acceptance asserts awvalid+wvalid, or arvalid.
- WR_AD: awvalid and wvalid are independent. Each holds until its own ready is seen, then deasserts the next cycle. Once both handshakes are done → WR_B with bready=1.
- WR_B: on bvalid → rsp pulse next cycle with status={0,bresp}; bready=0; → IDLE.
- RD_A: arvalid held until arready → RD_D with rready=1. RD_D: on rvalid → rsp pulse with rdata and status={0,rresp}; → IDLE.
- Minimum latency with all readies high and the slave responding immediately: accept at cycle 0, rsp_valid at cycle 3 for both reads and writes.
- Timeout: a counter clears on acceptance and increments every non-IDLE cycle. If it reaches TIMEOUT_CYCLES-1 with no completing B/R handshake in that cycle, all AXI valid/ready outputs drop next cycle, rsp is pulsed with status=3'b100 and rdata=0, and state → IDLE. A completing handshake in the expiry cycle wins over the timeout.
- Timeout is fault recovery only; it knowingly breaks AXI valid-hold.
- The rsp pulse coincides with o_cmd_ready=1, so a new command may be accepted in the same cycle.
- Reset mid-transaction: next cycle all outputs take reset values and no response is produced.

Decomposition:
- Shared package axi_lite_pkg: response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11; state encoding; STATUS_TIMEOUT_BIT=2.
- One sub-module axi_timeout_counter: clear, enable and expired outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Write addr 4'h8, data 32'hDEADBEEF, strb 4'hF; awready/wready=1; bvalid with bresp=2'b00 one cycle later → awaddr=8, wdata=DEADBEEF; rsp_valid at cycle 3, status 3'b000.
- Read addr 4'h4; arready delayed 3 cycles; rdata 32'h12345678, rresp 2'b00 → arvalid held 3 cycles; rsp rdata=32'h12345678, status 3'b000.
- Write with awready at cycle 1 and wready at cycle 4; bresp 2'b10 → awvalid drops after cycle 1, wvalid held to cycle 4, bready only after both handshakes; status 3'b010.
- Read with arready never asserted, TIMEOUT_CYCLES=16 → arvalid drops and rsp pulses at cycle 16 with status 3'b100, rdata 0; o_cmd_ready=1.
- Reset asserted in RD_D, then a back-to-back write is issued → all outputs at reset values next cycle, no rsp pulse, and the write completes normally.
